// File: rtl/acc_pkg.sv
// Shared types and default widths for the product accumulator datapath.
package acc_pkg;
   localparam int PW_DEFAULT   = 128;
   localparam int AW_DEFAULT   = 136;
   localparam int CNTW_DEFAULT = 16;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;
   typedef logic [PW_DEFAULT-1:0] product_t;
   typedef logic [AW_DEFAULT-1:0] acc_t;
endpackage

// File: rtl/acc_add_ovf.sv
// Combinational guard-banded adder: extends the product per its signedness
// and reports overflow under that beat's signed/unsigned rule.
module acc_add_ovf #(
   parameter int PW = 128,
   parameter int AW = 136
) (
   input  logic [AW-1:0] acc,
   input  logic [PW-1:0] product,
   input  logic          is_signed,
   output logic [AW-1:0] sum,
   output logic          ovf
);
   logic [AW-1:0] ext;
   logic          carry;

   always_comb begin
      ext          = is_signed ? {{(AW-PW){product[PW-1]}}, product}
                               : {{(AW-PW){1'b0}}, product};
      {carry, sum} = {1'b0, acc} + {1'b0, ext};
      // Signed: like-signed operands whose result flips sign; unsigned: carry out.
      if (is_signed)
         ovf = (acc[AW-1] == ext[AW-1]) && (sum[AW-1] != acc[AW-1]);
      else
         ovf = carry;
   end
endmodule

// File: rtl/product_accumulator.sv
// Accumulates groups of multiplier products (closed by in_last) and presents
// sum, beat count and sticky overflow on a valid/ready result port.
module product_accumulator
   import acc_pkg::*;
#(
   parameter int PW   = PW_DEFAULT,
   parameter int AW   = AW_DEFAULT,
   parameter int CNTW = CNTW_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PW-1:0]   in_product,
   input  logic            in_signed,
   input  logic            in_last,
   output logic            acc_valid,
   input  logic            acc_ready,
   output logic [AW-1:0]   acc_sum,
   output logic [CNTW-1:0] acc_count,
   output logic            acc_ovf
);
   acc_state_t    state, state_nxt;
   logic          accept;
   logic          release_grp;
   logic [AW-1:0] add_sum;
   logic          add_ovf;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (c == {CNTW{1'b1}}) ? c : c + CNTW'(1);
   endfunction

   acc_add_ovf #(.PW(PW), .AW(AW)) u_add (
      .acc       (acc_sum),
      .product   (in_product),
      .is_signed (in_signed),
      .sum       (add_sum),
      .ovf       (add_ovf)
   );

   assign accept      = in_valid && in_ready;
   assign release_grp = acc_valid && acc_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
            HOLD:        if (release_grp) state_nxt = IDLE;
            default:     state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      acc_valid = (state == HOLD);
      in_ready  = (state != HOLD) && !clr && !reset;
   end

   // Accumulator registers; clr and release both return them to the empty state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_sum   <= '0;
         acc_count <= '0;
         acc_ovf   <= 1'b0;
      end else if (clr || (state == HOLD && release_grp)) begin
         acc_sum   <= '0;
         acc_count <= '0;
         acc_ovf   <= 1'b0;
      end else if (accept) begin
         acc_sum   <= add_sum;
         acc_count <= sat_inc(acc_count);
         acc_ovf   <= acc_ovf | add_ovf;
      end
   end
endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;
  logic         clk = 1'b0;
  logic         reset, clr, in_valid, in_signed, in_last, acc_ready;
  logic [127:0] in_product;
  logic         in_ready, acc_valid, acc_ovf;
  logic [135:0] acc_sum;
  logic [15:0]  acc_count;
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] ALL1 = {128{1'b1}};
  localparam logic [127:0] SMAX = {1'b0, {127{1'b1}}};

  product_accumulator dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_signed(in_signed), .in_last(in_last),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_sum(acc_sum), .acc_count(acc_count), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic fail(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    errors++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic beat(input logic [127:0] p, input logic s, input logic l);
    in_valid = 1'b1; in_product = p; in_signed = s; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_result();
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
  endtask

  task automatic burst(input int n, input logic [127:0] p, input logic s);
    for (int i = 0; i < n; i++) beat(p, s, (i == n - 1));
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_last = 1'b0; acc_ready = 1'b0; in_product = '0;
    #12;
    checks++; if (acc_valid !== 1'b0) fail("rst_valid", acc_valid, 1'b0);
    checks++; if (in_ready !== 1'b0) fail("rst_ready", in_ready, 1'b0);
    checks++; if (acc_sum !== 136'h0) fail("rst_sum", acc_sum, 136'h0);
    checks++; if (acc_count !== 16'd0) fail("rst_count", acc_count, 16'd0);
    checks++; if (acc_ovf !== 1'b0) fail("rst_ovf", acc_ovf, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) fail("ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    beat(128'h5, 1'b1, 1'b0);
    checks++; if (acc_sum !== 136'h5) fail("sg_first_sum", acc_sum, 136'h5);
    checks++; if (acc_valid !== 1'b0) fail("sg_first_valid", acc_valid, 1'b0);
    beat(ALL1, 1'b1, 1'b0);
    beat(128'hA, 1'b1, 1'b1);
    checks++; if (acc_valid !== 1'b1) fail("sg_valid", acc_valid, 1'b1);
    checks++; if (acc_sum !== 136'hE) fail("sg_sum", acc_sum, 136'hE);
    checks++; if (acc_count !== 16'd3) fail("sg_count", acc_count, 16'd3);
    checks++; if (acc_ovf !== 1'b0) fail("sg_ovf", acc_ovf, 1'b0);

    in_valid = 1'b1; in_product = 128'h7; in_signed = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) fail("bp_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      checks++; if (acc_sum !== 136'hE) fail("bp_sum", acc_sum, 136'hE);
      checks++; if (acc_count !== 16'd3) fail("bp_count", acc_count, 16'd3);
      checks++; if (acc_valid !== 1'b1) fail("bp_valid", acc_valid, 1'b1);
    end
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    checks++; if (acc_valid !== 1'b0) fail("bubble_valid", acc_valid, 1'b0);
    checks++; if (acc_sum !== 136'h0) fail("bubble_sum", acc_sum, 136'h0);
    checks++; if (acc_count !== 16'd0) fail("bubble_count", acc_count, 16'd0);
    checks++; if (in_ready !== 1'b1) fail("bubble_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (acc_count !== 16'd1) fail("pend_count", acc_count, 16'd1);
    checks++; if (acc_sum !== 136'h7) fail("pend_sum", acc_sum, 136'h7);

    in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1; in_last = 1'b0;
    checks++; if (acc_valid !== 1'b0) fail("idle_accum_valid", acc_valid, 1'b0);
    checks++; if (acc_count !== 16'd1) fail("idle_accum_count", acc_count, 16'd1);

    clr = 1'b1; in_valid = 1'b1; in_product = 128'h9;
    #1;
    checks++; if (in_ready !== 1'b0) fail("clr_accum_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checks++; if (acc_sum !== 136'h0) fail("clr_accum_sum", acc_sum, 136'h0);
    checks++; if (acc_count !== 16'd0) fail("clr_accum_count", acc_count, 16'd0);
    checks++; if (acc_valid !== 1'b0) fail("clr_accum_valid", acc_valid, 1'b0);

    beat(128'h3, 1'b0, 1'b1);
    checks++; if (acc_valid !== 1'b1) fail("single_valid", acc_valid, 1'b1);
    checks++; if (acc_count !== 16'd1) fail("single_count", acc_count, 16'd1);
    checks++; if (acc_sum !== 136'h3) fail("single_sum", acc_sum, 136'h3);
    clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checks++; if (acc_valid !== 1'b0) fail("clr_hold_valid", acc_valid, 1'b0);
    checks++; if (acc_sum !== 136'h0) fail("clr_hold_sum", acc_sum, 136'h0);
    checks++; if (acc_count !== 16'd0) fail("clr_hold_count", acc_count, 16'd0);

    beat(ALL1, 1'b1, 1'b0);
    beat(128'h1, 1'b0, 1'b1);
    checks++; if (acc_sum !== 136'h0) fail("mixed_sum", acc_sum, 136'h0);
    checks++; if (acc_ovf !== 1'b1) fail("mixed_ovf", acc_ovf, 1'b1);
    release_result();
    checks++; if (acc_ovf !== 1'b0) fail("mixed_release_ovf", acc_ovf, 1'b0);

    burst(257, ALL1, 1'b0);
    checks++; if (acc_count !== 16'd257) fail("uw257_count", acc_count, 16'd257);
    checks++; if (acc_ovf !== 1'b1) fail("uw257_ovf", acc_ovf, 1'b1);
    checks++; if (acc_sum !== 136'h00_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFEFF)
      fail("uw257_sum", acc_sum, 136'h00_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFEFF);
    release_result();
    burst(256, ALL1, 1'b0);
    checks++; if (acc_count !== 16'd256) fail("uw256_count", acc_count, 16'd256);
    checks++; if (acc_ovf !== 1'b0) fail("uw256_ovf", acc_ovf, 1'b0);
    checks++; if (acc_sum !== 136'hFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00)
      fail("uw256_sum", acc_sum, 136'hFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00);
    release_result();

    burst(256, SMAX, 1'b1);
    checks++; if (acc_ovf !== 1'b0) fail("so256_ovf", acc_ovf, 1'b0);
    checks++; if (acc_sum !== 136'h7F_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00)
      fail("so256_sum", acc_sum, 136'h7F_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00);
    release_result();
    burst(257, SMAX, 1'b1);
    checks++; if (acc_ovf !== 1'b1) fail("so257_ovf", acc_ovf, 1'b1);
    checks++; if (acc_sum !== 136'h80_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFEFF)
      fail("so257_sum", acc_sum, 136'h80_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFEFF);
    release_result();

    beat(128'h1, 1'b0, 1'b0);
    beat(128'h2, 1'b0, 1'b0);
    checks++; if (acc_sum !== 136'h3) fail("pre_rst_sum", acc_sum, 136'h3);
    #2 reset = 1'b1;
    #1;
    checks++; if (acc_sum !== 136'h0) fail("arst_sum", acc_sum, 136'h0);
    checks++; if (acc_count !== 16'd0) fail("arst_count", acc_count, 16'd0);
    checks++; if (in_ready !== 1'b0) fail("arst_ready", in_ready, 1'b0);
    checks++; if (acc_valid !== 1'b0) fail("arst_valid", acc_valid, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    beat(128'h9, 1'b0, 1'b1);
    checks++; if (acc_sum !== 136'h9) fail("post_rst_sum", acc_sum, 136'h9);
    checks++; if (acc_count !== 16'd1) fail("post_rst_count", acc_count, 16'd1);
    checks++; if (acc_valid !== 1'b1) fail("post_rst_valid", acc_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 64x64 multiplier's 128-bit product (signed or unsigned).
- Accepts one product per cycle over a valid/ready handshake and accumulates a group of products, terminated by `in_last`, into a guard-banded accumulator.
- Presents the group result, beat count and a sticky overflow flag on a registered valid/ready output.
- Forms the accumulate half of a multiply-accumulate datapath.

Parameters:
- PW, 128, product width (matches multiplier output width)
- AW, 136, accumulator width; AW-PW = 8 guard bits
- CNTW, 16, beat counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort/clear of current group
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_product  input  PW  product from multiplier
- in_signed  input  1  1 = two's-complement product, 0 = unsigned
- in_last  input  1  beat closes the current group
- acc_valid  output  1  group result available
- acc_ready  input  1  consumer takes result
- acc_sum  output  AW  accumulated sum
- acc_count  output  CNTW  beats in group
- acc_ovf  output  1  sticky overflow for group

Behaviour:
- Reset: one clock `clk`; `reset` is asynchronous and active-high. While `reset`=1:
  - state=IDLE; `acc_sum`=0, `acc_count`=0, `acc_ovf`=0, `acc_valid`=0, `in_ready`=0.
  - `in_ready` goes to 1 on the first cycle after reset deasserts.
- States: IDLE (empty accumulator), ACCUM (group in progress), HOLD (result presented).
- `in_ready` = (state != HOLD) && !clr && !reset.
- Beat accepted when `in_valid` && `in_ready` at a rising edge. On accept:
  - ext = sign-extend `in_product` to AW bits if `in_signed`=1, else zero-extend.
  - `acc_sum` <= `acc_sum` + ext (mod 2^AW). The result is visible the cycle after accept (latency 1).
  - `acc_count` <= `acc_count`+1, saturating at 2^CNTW-1.
  - Overflow, evaluated per beat using that beat's `in_signed`:
    - signed: operand MSBs equal and result MSB differs;
    - unsigned: carry out of bit AW-1.
  - `acc_ovf` <= `acc_ovf` | overflow. It is sticky until the group is released.
  - Next state: if `in_last`, go to HOLD; else go to ACCUM.
- In HOLD:
  - `acc_valid`=1; `acc_sum`, `acc_count` and `acc_ovf` are held stable.
  - On `acc_valid` && `acc_ready`: next cycle clears `acc_sum`, `acc_count` and `acc_ovf` to 0, sets `acc_valid`=0, and goes to IDLE.
  - Back-to-back groups therefore incur one bubble cycle.
- `acc_valid` is registered and is 1 only in HOLD.
- `clr`:
  - Highest priority below `reset`. On the edge where `clr`=1, go to IDLE and zero all accumulator state.
  - Drops `acc_valid` even if the result was not taken.
  - No beat is accepted in a `clr` cycle.
- Mixed `in_signed` within a group is legal; each beat uses its own extension and overflow rule.
- Single-beat group (`in_last` on the first beat): IDLE -> HOLD, `acc_count`=1.
- `in_valid`=0 in ACCUM leaves state unchanged indefinitely.
- `in_last` with `in_valid`=0 is ignored.
- `reset` asserted mid-group or in HOLD: all outputs go to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package `acc_pkg`:
  - `acc_state_t` enum {IDLE, ACCUM, HOLD};
  - localparams for PW, AW and CNTW defaults;
  - typedefs `product_t` [PW-1:0] and `acc_t` [AW-1:0].
- Sub-module `acc_add_ovf`: combinational AW-bit adder taking `acc`, `product` and `is_signed`. It performs the extension internally and returns the sum and an overflow bit.
- The top level holds the FSM, the registers and the handshake logic.

Test Plan:
- Signed group: beats 128'h5, 128'hFF..FF (-1), 128'hA with `in_last`, `in_signed`=1 -> `acc_valid`=1 the cycle after the third accept; `acc_sum`=136'hE, `acc_count`=3, `acc_ovf`=0.
- Unsigned wrap: 257 beats of 128'hFF..FF with `in_signed`=0, `in_last` on the final beat -> `acc_count`=257, `acc_ovf`=1, `acc_sum`=136'h00_FFFF..FEFF (that is, 2^128-257). The same test with 256 beats -> `acc_ovf`=0, `acc_sum`=2^136-256.
- Signed overflow: 257 beats of 128'h7FFF..FF with `in_signed`=1 -> `acc_ovf`=1. With 256 beats -> `acc_ovf`=0, `acc_sum`=2^135-256.
- Backpressure: a group ends; hold `acc_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0 throughout, no beat accepted, outputs stable. When `acc_ready`=1: one bubble cycle, then the pending beat is accepted and its group starts at `acc_count`=1.
- `clr` in HOLD and in ACCUM: pulse `clr` with `in_valid`=1 -> beat not accepted, `acc_valid`=0, `acc_sum`=0, `acc_count`=0 on the next cycle, state IDLE.
- Asynchronous reset: assert `reset` mid-group at a non-edge time -> all outputs zero before the next `clk` edge; first group after release starts from 0.
